// File: rtl/byte_ram_pkg.sv
// Shared encodings for byte_ram: access sizes, FSM states and the alignment check.
package byte_ram_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Misaligned offset, or a double access on a memory whose word is only 4 bytes.
    function automatic logic access_err(input logic [1:0] size, input logic [2:0] offset,
                                        input int wordsize);
        logic [2:0] amask;
        amask = 3'((1 << size) - 1);
        return ((offset & amask) != 3'd0) || (size == SZ_DOUBLE && wordsize == 4);
    endfunction

endpackage

// File: rtl/byte_ram_lane.sv
// One byte lane of storage: write-enabled byte array with a registered read port.
module byte_ram_lane #(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // rdata only moves on an accepted request, so it holds the load result while stalled.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/byte_ram.sv
// Byte-addressable RAM with sized, sign/zero-extending loads and a fixed-latency
// single-outstanding request/response handshake.
module byte_ram
    import byte_ram_pkg::*;
#(
    parameter int WORDSIZE = 4,
    parameter int MEMSIZE  = 32 * 1024,
    parameter int LATENCY  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [1:0]                   req_size,
    input  logic                         req_unsigned,
    input  logic [$clog2(MEMSIZE)-1:0]   req_addr,
    input  logic [WORDSIZE*8-1:0]        req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WORDSIZE*8-1:0]        rsp_rdata,
    output logic                         rsp_error
);

    localparam int W     = WORDSIZE * 8;
    localparam int AW    = $clog2(MEMSIZE);
    localparam int OW    = $clog2(WORDSIZE);
    localparam int DEPTH = MEMSIZE / WORDSIZE;

    state_t        state;
    logic [1:0]    cnt;
    logic          wr_q, err_q, uns_q;
    logic [1:0]    size_q;
    logic [OW-1:0] off_q;

    logic                accept, err;
    logic [OW-1:0]       off;
    logic [AW-OW-1:0]    widx;
    logic [WORDSIZE-1:0] be;
    logic [W-1:0]        wshift, word;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready & ~reset;
    assign off       = req_addr[OW-1:0];
    assign widx      = req_addr[AW-1:OW];
    assign err       = access_err(req_size, 3'(off), WORDSIZE);
    assign wshift    = req_wdata << (int'(off) * 8);

    always_comb begin
        int lo, nb;
        lo = int'(off);
        nb = 1 << req_size;
        be = '0;
        for (int i = 0; i < WORDSIZE; i++)
            be[i] = accept & req_write & ~err & (i >= lo) & (i < lo + nb);
    end

    for (genvar g = 0; g < WORDSIZE; g++) begin : g_lane
        byte_ram_lane #(.DEPTH(DEPTH), .AW(AW - OW)) u_lane (
            .clock (clock),
            .en    (accept),
            .we    (be[g]),
            .addr  (widx),
            .wdata (wshift[8*g +: 8]),
            .rdata (word[8*g +: 8])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rsp_valid <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_BYTE;
            off_q     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    wr_q   <= req_write;
                    err_q  <= err;
                    uns_q  <= req_unsigned;
                    size_q <= req_size;
                    off_q  <= off;
                    if (LATENCY == 1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;
                    end
                end
                WAIT: if (cnt == 2'd0) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Align the lane read to bit 0, then fill above the access width with sign or zeros.
    logic [W-1:0] sh, mask, res;
    logic         sgn;

    always_comb begin
        sh = word >> (int'(off_q) * 8);
        case (size_q)
            SZ_BYTE: begin mask = W'(8'hFF);          sgn = sh[7];   end
            SZ_HALF: begin mask = W'(16'hFFFF);       sgn = sh[15];  end
            SZ_WORD: begin mask = W'(32'hFFFF_FFFF);  sgn = sh[31];  end
            default: begin mask = '1;                 sgn = sh[W-1]; end
        endcase
        res = (sh & mask) | ({W{sgn & ~uns_q}} & ~mask);
    end

    assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? res : '0;
    assign rsp_error = rsp_valid & err_q;

endmodule
